jtag_master_driver: RTL and testbench

//  Host-side JTAG driver: turns scan commands into TCK/TMS/TDI waveforms and captures TDO.

---
 rtl/jtag_master_pkg.sv | 58 +++++
 rtl/jtag_master_driver_tck_gen.sv | 59 +++++
 rtl/jtag_master_driver.sv | 244 ++++++++++++++++++++++++
 tb/tb_jtag_master_driver.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_master_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : jtag_master_pkg                                              |
// | Description : Shared types, TMS sequences and width helper for the JTAG    |
// |               master driver.                                               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package jtag_master_pkg;

    typedef enum logic [1:0] {
        CMD_RESET   = 2'd0,
        CMD_IR_SCAN = 2'd1,
        CMD_DR_SCAN = 2'd2,
        CMD_IDLE    = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_AUTO_RST  = 3'd0,
        ST_IDLE      = 3'd1,
        ST_PREAMBLE  = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_POSTAMBLE = 3'd4,
        ST_RESP      = 3'd5,
        ST_IDLE_RUN  = 3'd6
    } state_e;

    // TMS sequences are stored bit0-first: bit0 is driven on the first TCK.
    localparam logic [7:0] c_tms_reset_seq = 8'b0001_1111;
    localparam logic [7:0] c_tms_ir_pre    = 8'b0000_0011;
    localparam logic [7:0] c_tms_dr_pre    = 8'b0000_0001;
    localparam logic [1:0] c_tms_post      = 2'b01;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic logic [7:0] pre_seq(input cmd_type_e t);
        case (t)
            CMD_IR_SCAN: return c_tms_ir_pre;
            CMD_DR_SCAN: return c_tms_dr_pre;
            default:     return c_tms_reset_seq;
        endcase
    endfunction

    function automatic logic [2:0] pre_last(input cmd_type_e t);
        case (t)
            CMD_IR_SCAN: return 3'd3;
            CMD_DR_SCAN: return 3'd2;
            CMD_RESET:   return 3'd5;
            default:     return 3'd0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_master_driver_tck_gen.sv
// +----------------------------------------------------------------------------+
// | Module      : jtag_tck_gen                                                 |
// | Description : TCK divider with run enable; strobes flag the clk edge on    |
// |               which TCK will rise or fall. Parks TCK low when not running. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module jtag_tck_gen #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic run_i,
    output logic tck_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int DW = $clog2(HALF_DIV + 1);
    localparam logic [DW-1:0] c_div_last = DW'(HALF_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          tck_q, tck_d;
    logic          w_edge;

    always_comb begin
        w_edge = run_i && (div_q == c_div_last);
        div_d  = div_q;
        tck_d  = tck_q;
        if (!run_i) begin
            div_d = '0;
            tck_d = 1'b0;
        end else if (w_edge) begin
            div_d = '0;
            tck_d = ~tck_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q <= '0;
            tck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            tck_q <= tck_d;
        end
    end

    assign tck_o      = tck_q;
    assign rise_stb_o = w_edge & ~tck_q;
    assign fall_stb_o = w_edge &  tck_q;

endmodule

`default_nettype wire

// File: rtl/jtag_master_driver.sv
// +----------------------------------------------------------------------------+
// | Module      : jtag_master_driver                                           |
// | Description : Host-side JTAG master: scan commands in, TCK/TMS/TDI out,    |
// |               captured TDO back as a response. Optional JTAG_MASTER_       |
// |               LOOPBACK_EN adds loopback_i (capture TDI instead of TDO).    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module jtag_master_driver
    import jtag_master_pkg::*;
#(
    parameter int MAX_LEN  = 32,
    parameter int HALF_DIV = 4,
    localparam int LW      = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_type_i,
    input  logic [LW-1:0]      cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               rsp_err_o,
    output logic               busy_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
`ifdef JTAG_MASTER_LOOPBACK_EN
    input  logic               loopback_i,
`endif
    input  logic               tdo_i
);

    state_e             state_q;
    cmd_type_e          type_q;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      bit_cnt_q;
    logic [2:0]         pre_cnt_q;
    logic [MAX_LEN-1:0] data_q;
    logic [MAX_LEN-1:0] mask_q;
    logic [MAX_LEN-1:0] rsp_data_q;
    logic               tms_q;
    logic               tdi_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic               busy_q;

    logic               w_run;
    logic               w_rise;
    logic               w_fall;
    logic               w_cap;
    logic               w_last_bit;
    logic               w_len_bad;
    logic [7:0]         w_pre_seq;
    logic [2:0]         w_pre_last;

    jtag_tck_gen #(
        .HALF_DIV   (HALF_DIV)
    ) u_tck_gen (
        .clk        (clk),
        .rst_n_i    (rst_n_i),
        .run_i      (w_run),
        .tck_o      (tck_o),
        .rise_stb_o (w_rise),
        .fall_stb_o (w_fall)
    );

    assign w_run = state_q inside {ST_AUTO_RST, ST_PREAMBLE, ST_SHIFT,
                                   ST_POSTAMBLE, ST_IDLE_RUN};

`ifdef JTAG_MASTER_LOOPBACK_EN
    assign w_cap = loopback_i ? tdi_q : tdo_i;
`else
    assign w_cap = tdo_i;
`endif

    assign w_last_bit = (bit_cnt_q == len_q - LW'(1));
    assign w_len_bad  = (cmd_len_i == '0) || (cmd_len_i > LW'(MAX_LEN));
    // Auto-reset runs with type_q parked at CMD_RESET, so it shares the preamble path.
    assign w_pre_seq  = pre_seq(type_q);
    assign w_pre_last = pre_last(type_q);

    // TMS/TDI change on the same clk edge as the TCK fall; TDO is taken on the rise edge.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_AUTO_RST;
            type_q      <= CMD_RESET;
            len_q       <= '0;
            bit_cnt_q   <= '0;
            pre_cnt_q   <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            rsp_data_q  <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_AUTO_RST, ST_PREAMBLE: begin
                    if (w_fall) begin
                        if (pre_cnt_q == w_pre_last) begin
                            pre_cnt_q <= '0;
                            if (state_q == ST_AUTO_RST) begin
                                state_q     <= ST_IDLE;
                                busy_q      <= 1'b0;
                                cmd_ready_q <= 1'b1;
                            end else if (type_q == CMD_RESET) begin
                                state_q <= ST_RESP;
                            end else begin
                                state_q   <= ST_SHIFT;
                                bit_cnt_q <= '0;
                                mask_q    <= MAX_LEN'(1);
                                tms_q     <= (len_q == LW'(1));
                                tdi_q     <= data_q[0];
                            end
                        end else begin
                            pre_cnt_q <= pre_cnt_q + 3'd1;
                            tms_q     <= w_pre_seq[pre_cnt_q + 3'd1];
                        end
                    end
                end

                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        type_q      <= cmd_type_e'(cmd_type_i);
                        len_q       <= cmd_len_i;
                        data_q      <= cmd_data_i;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        pre_cnt_q   <= '0;
                        bit_cnt_q   <= '0;
                        tdi_q       <= 1'b0;
                        case (cmd_type_e'(cmd_type_i))
                            CMD_IDLE: begin
                                tms_q <= 1'b0;
                                if (cmd_len_i == '0) begin
                                    state_q <= ST_RESP;
                                end else begin
                                    state_q <= ST_IDLE_RUN;
                                end
                            end
                            CMD_RESET: begin
                                state_q <= ST_PREAMBLE;
                                tms_q   <= c_tms_reset_seq[0];
                            end
                            default: begin
                                if (w_len_bad) begin
                                    state_q   <= ST_RESP;
                                    rsp_err_q <= 1'b1;
                                end else begin
                                    state_q <= ST_PREAMBLE;
                                    tms_q   <= 1'b1;
                                end
                            end
                        endcase
                    end
                end

                ST_SHIFT: begin
                    if (w_rise && w_cap) begin
                        rsp_data_q <= rsp_data_q | mask_q;
                    end
                    if (w_fall) begin
                        if (w_last_bit) begin
                            state_q   <= ST_POSTAMBLE;
                            pre_cnt_q <= '0;
                            tms_q     <= c_tms_post[0];
                            tdi_q     <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + LW'(1);
                            mask_q    <= mask_q << 1;
                            data_q    <= data_q >> 1;
                            tdi_q     <= data_q[1];
                            tms_q     <= ((bit_cnt_q + LW'(1)) == (len_q - LW'(1)));
                        end
                    end
                end

                ST_POSTAMBLE: begin
                    if (w_fall) begin
                        if (pre_cnt_q == 3'd1) begin
                            state_q <= ST_RESP;
                        end else begin
                            pre_cnt_q <= 3'd1;
                            tms_q     <= c_tms_post[1];
                        end
                    end
                end

                ST_IDLE_RUN: begin
                    if (w_fall) begin
                        if (w_last_bit) begin
                            state_q <= ST_RESP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + LW'(1);
                        end
                    end
                end

                ST_RESP: begin
                    // Entry cycle only raises valid, so valid lands one clk after the last TCK fall.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q   <= ST_AUTO_RST;
                    type_q    <= CMD_RESET;
                    pre_cnt_q <= '0;
                    tms_q     <= 1'b1;
                    tdi_q     <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

endmodule

`default_nettype wire

// File: tb/tb_jtag_master_driver.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_jtag_master_driver                                        |
// | Description : Directed bench for jtag_master_driver with a behavioural TAP |
// |               (IR=4b, TCR behind SAMPLE_PRELOAD). JTAG_MASTER_LOOPBACK_EN  |
// |               enables the loopback scenario.                               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_jtag_master_driver;

    localparam int LW = 6;
    localparam logic [31:0] c_tcr_mask = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'd0;
    logic [LW-1:0] cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        tck, tms, tdi;
    logic        tdo = 1'b0;
    logic        loopback = 1'b0;

    int checks = 0;
    int failures = 0;

    jtag_master_driver #(.MAX_LEN(32), .HALF_DIV(4)) dut (
        .clk         (clk),
        .rst_n_i     (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_type_i  (cmd_type),
        .cmd_len_i   (cmd_len),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .tck_o       (tck),
        .tms_o       (tms),
        .tdi_o       (tdi),
`ifdef JTAG_MASTER_LOOPBACK_EN
        .loopback_i  (loopback),
`endif
        .tdo_i       (tdo)
    );

    always #5 clk = ~clk;

    // Behavioural TAP: state numbering TLR=0 RTI=1 SelDR=2 CapDR=3 ShDR=4 Ex1DR=5
    // PsDR=6 Ex2DR=7 UpDR=8 SelIR=9 CapIR=10 ShIR=11 Ex1IR=12 PsIR=13 Ex2IR=14 UpIR=15
    int          tap_st = 0;
    logic [3:0]  ir_sr = 4'h0;
    logic [3:0]  ir = 4'hF;
    logic [31:0] dr_sr = 32'h0;
    logic [31:0] tcr = 32'h1234_5678;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            0:  return m ? 0  : 1;
            1:  return m ? 2  : 1;
            2:  return m ? 9  : 3;
            3:  return m ? 5  : 4;
            4:  return m ? 5  : 4;
            5:  return m ? 8  : 6;
            6:  return m ? 7  : 6;
            7:  return m ? 8  : 4;
            8:  return m ? 2  : 1;
            9:  return m ? 0  : 10;
            10: return m ? 12 : 11;
            11: return m ? 12 : 11;
            12: return m ? 15 : 13;
            13: return m ? 14 : 13;
            14: return m ? 15 : 11;
            15: return m ? 2  : 1;
            default: return 0;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_st)
            3:  dr_sr <= (ir == 4'h2) ? tcr : 32'h0;
            4:  dr_sr <= {tdi, dr_sr[31:1]};
            8:  if (ir == 4'h2) tcr <= dr_sr & c_tcr_mask;
            10: ir_sr <= 4'b0001;
            11: ir_sr <= {tdi, ir_sr[3:1]};
            15: ir <= ir_sr;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
    end

    always @(negedge tck) begin
        tdo <= (tap_st == 4) ? dr_sr[0] : (tap_st == 11) ? ir_sr[0] : 1'b0;
    end

    int   n_rise = 0;
    logic tms_log [0:1023];
    logic tdi_log [0:1023];

    always @(posedge tck) begin
        tms_log[n_rise[9:0]] <= tms;
        tdi_log[n_rise[9:0]] <= tdi;
        n_rise <= n_rise + 1;
    end

    initial begin
        #300_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // One command through handshake; rsp_ready held low for 'hold' clocks after valid.
    task automatic do_cmd(input logic [1:0] t, input logic [LW-1:0] l, input logic [31:0] d,
                          input int hold, output logic [31:0] rd, output logic re,
                          output int lat, output int nt, output logic to,
                          output logic stable, output logic post_ok, output int base);
        int w;
        to = 1'b0; rd = '0; re = 1'b0; lat = 0; stable = 1'b1; post_ok = 1'b0;
        base = n_rise;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_type = t; cmd_len = l; cmd_data = d;
        w = 0;
        while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
        if (!cmd_ready) begin
            to = 1'b1; cmd_valid = 1'b0; nt = n_rise - base;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
        nt = n_rise - base;
        if (!rsp_valid) begin to = 1'b1; return; end
        rd = rsp_data; re = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_data !== rd || rsp_err !== re || cmd_ready || tck) stable = 1'b0;
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        post_ok = cmd_ready && !rsp_valid && !busy;
    endtask

    task automatic release_reset(output int w, output int nt, output logic [5:0] tv, output logic rv_seen);
        int base;
        base = n_rise; rv_seen = 1'b0; w = 0;
        @(negedge clk); rst_n = 1'b1;
        while (!cmd_ready && w < 100) begin
            @(posedge clk); #1; w++;
            if (rsp_valid) rv_seen = 1'b1;
        end
        nt = n_rise - base;
        for (int i = 0; i < 6; i++) tv[i] = tms_log[(base + i) % 1024];
    endtask

    task automatic test_reset;
        int w, nt; logic [5:0] tv; logic rv;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tck, tms, tdi, cmd_ready, rsp_valid, rsp_err, busy} !== 7'b0100001 || rsp_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_values got=%b/%h exp=0100001/00000000",
                     {tck, tms, tdi, cmd_ready, rsp_valid, rsp_err, busy}, rsp_data);
        end
        release_reset(w, nt, tv, rv);
        checks++; if (!cmd_ready || w > 50) begin failures++; $display("FAIL t1_ready_by_50 got=%0d exp<=50", w); end
        checks++; if (nt !== 6) begin failures++; $display("FAIL t1_tck_count got=%0d exp=6", nt); end
        checks++; if (tv !== 6'b011111) begin failures++; $display("FAIL t1_tms_seq got=%b exp=011111", tv); end
        checks++; if (rv !== 1'b0) begin failures++; $display("FAIL t1_no_rsp got=%b exp=0", rv); end
    endtask

    task automatic test_ir_scan;
        logic [31:0] rd; logic re, to, st, po; int lat, nt, base;
        logic [9:0] tv, dv;
        do_cmd(2'd1, 6'd4, 32'h2, 0, rd, re, lat, nt, to, st, po, base);
        for (int i = 0; i < 10; i++) begin
            tv[i] = tms_log[(base + i) % 1024];
            dv[i] = tdi_log[(base + i) % 1024];
        end
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL t2_timeout got=%b exp=0", to); end
        checks++; if (nt !== 10) begin failures++; $display("FAIL t2_tck_count got=%0d exp=10", nt); end
        checks++; if (tv !== 10'b0110000011) begin failures++; $display("FAIL t2_tms_seq got=%b exp=0110000011", tv); end
        checks++; if (dv !== 10'b0000100000) begin failures++; $display("FAIL t2_tdi_seq got=%b exp=0000100000", dv); end
        checks++; if (rd !== 32'h1 || re !== 1'b0) begin failures++; $display("FAIL t2_rsp got=%h/%b exp=00000001/0", rd, re); end
        checks++; if (po !== 1'b1) begin failures++; $display("FAIL t2_idle_after_rsp got=%b exp=1", po); end
    endtask

    task automatic test_dr_scan;
        logic [31:0] rd; logic re, to, st, po; int lat, nt, base;
        do_cmd(2'd2, 6'd32, 32'h8000_00A5, 0, rd, re, lat, nt, to, st, po, base);
        checks++; if (nt !== 37) begin failures++; $display("FAIL t3_tck_count got=%0d exp=37", nt); end
        checks++; if (lat !== 297) begin failures++; $display("FAIL t3_latency got=%0d exp=297", lat); end
        checks++; if (rd !== 32'h1234_5678 || re !== 1'b0) begin failures++; $display("FAIL t3_rsp got=%h/%b exp=12345678/0", rd, re); end
        checks++; if (tcr !== 32'h0000_00A5) begin failures++; $display("FAIL t3_tcr got=%h exp=000000a5", tcr); end
    endtask

    task automatic test_reset_and_idle_cmds;
        logic [31:0] rd; logic re, to, st, po; int lat, nt, base;
        logic [5:0] tv; logic [4:0] iv;
        do_cmd(2'd0, 6'd7, 32'hFFFF_FFFF, 0, rd, re, lat, nt, to, st, po, base);
        for (int i = 0; i < 6; i++) tv[i] = tms_log[(base + i) % 1024];
        checks++; if (nt !== 6 || tv !== 6'b011111) begin failures++; $display("FAIL reset_cmd got=%0d/%b exp=6/011111", nt, tv); end
        checks++; if (rd !== 32'h0 || re !== 1'b0 || to !== 1'b0) begin failures++; $display("FAIL reset_cmd_rsp got=%h/%b exp=00000000/0", rd, re); end
        do_cmd(2'd3, 6'd5, 32'hFFFF_FFFF, 0, rd, re, lat, nt, to, st, po, base);
        for (int i = 0; i < 5; i++) iv[i] = tms_log[(base + i) % 1024];
        checks++; if (nt !== 5 || iv !== 5'b00000) begin failures++; $display("FAIL idle5 got=%0d/%b exp=5/00000", nt, iv); end
        checks++; if (lat !== 41 || rd !== 32'h0 || re !== 1'b0) begin failures++; $display("FAIL idle5_rsp got=%0d/%h/%b exp=41/0/0", lat, rd, re); end
        do_cmd(2'd3, 6'd0, 32'h0, 0, rd, re, lat, nt, to, st, po, base);
        checks++; if (nt !== 0 || lat !== 1 || re !== 1'b0) begin failures++; $display("FAIL idle0 got=%0d/%0d/%b exp=0/1/0", nt, lat, re); end
    endtask

    task automatic test_illegal;
        logic [31:0] rd; logic re, to, st, po; int lat, nt, base;
        do_cmd(2'd2, 6'd0, 32'hFFFF_FFFF, 0, rd, re, lat, nt, to, st, po, base);
        checks++; if (nt !== 0 || lat !== 1 || re !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL t4_len0 got=%0d/%0d/%b/%h exp=0/1/1/0", nt, lat, re, rd); end
        do_cmd(2'd1, 6'd33, 32'hFFFF_FFFF, 0, rd, re, lat, nt, to, st, po, base);
        checks++; if (nt !== 0 || lat !== 1 || re !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL t4_len33 got=%0d/%0d/%b/%h exp=0/1/1/0", nt, lat, re, rd); end
        checks++; if (po !== 1'b1) begin failures++; $display("FAIL t4_idle_after_err got=%b exp=1", po); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic re, to, st, po; int lat, nt, base;
        do_cmd(2'd2, 6'd8, 32'h0000_005A, 100, rd, re, lat, nt, to, st, po, base);
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL t5_stable got=%b exp=1", st); end
        checks++; if (rd !== 32'h0000_00A5 || re !== 1'b0) begin failures++; $display("FAIL t5_rsp got=%h/%b exp=000000a5/0", rd, re); end
        do_cmd(2'd3, 6'd3, 32'h0, 0, rd, re, lat, nt, to, st, po, base);
        checks++; if (to !== 1'b0 || nt !== 3) begin failures++; $display("FAIL t5_next_cmd got=%b/%0d exp=0/3", to, nt); end
    endtask

    task automatic test_mid_reset;
        int base, w, nt; logic [5:0] tv; logic rv;
        base = n_rise;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_type = 2'd2; cmd_len = 6'd32; cmd_data = 32'hFFFF_0000;
        w = 0;
        while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        w = 0;
        while ((n_rise - base) < 14 && w < 500) begin @(posedge clk); #1; w++; end
        checks++; if ((n_rise - base) !== 14 || !tck) begin failures++; $display("FAIL t6_reach_bit10 got=%0d exp=14", n_rise - base); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tck, tms, tdi, cmd_ready, rsp_valid, busy} !== 6'b010001) begin
            failures++; $display("FAIL t6_async_reset got=%b exp=010001", {tck, tms, tdi, cmd_ready, rsp_valid, busy});
        end
        repeat (2) @(negedge clk);
        release_reset(w, nt, tv, rv);
        checks++; if (!cmd_ready || w > 50 || nt !== 6 || tv !== 6'b011111 || rv !== 1'b0) begin
            failures++; $display("FAIL t6_replay got=%0d/%0d/%b/%b exp<=50/6/011111/0", w, nt, tv, rv);
        end
    endtask

`ifdef JTAG_MASTER_LOOPBACK_EN
    task automatic test_loopback;
        logic [31:0] rd; logic re, to, st, po; int lat, nt, base;
        loopback = 1'b1;
        do_cmd(2'd2, 6'd16, 32'h0000_1234, 0, rd, re, lat, nt, to, st, po, base);
        loopback = 1'b0;
        checks++; if (rd !== 32'h0000_1234 || nt !== 21) begin failures++; $display("FAIL t7_loopback got=%h/%0d exp=00001234/21", rd, nt); end
    endtask
`endif

    initial begin
        test_reset();
        test_ir_scan();
        test_dr_scan();
        test_reset_and_idle_cmds();
        test_illegal();
        test_backpressure();
        test_mid_reset();
`ifdef JTAG_MASTER_LOOPBACK_EN
        test_loopback();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
